// File: rtl/usb_ep_out_rr_arbiter_pkg.sv
// Shared definitions for the USB OUT endpoint round-robin arbiter.
// Holds the arbiter state type and the index-width helper.
// The IN-side arbiter uses the same helper.
package usb_ep_out_rr_arbiter_pkg;

    // Arbiter has no owner (IDLE) or one owner holding the data path (BUSY)
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } usbArbState_t;

    // Width of an endpoint index; never narrower than one bit
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_ep_out_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating first-one finder.
// Searches upward from 'start' (wrapping modulo N) for the first request
// that is not masked by 'excl'. Returns the winner as a one-hot vector and
// as an index, plus a flag saying whether anything was found.
// The IN-side arbiter uses this module too.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     excl,
    output logic [N-1:0]     pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [N-1:0] cand;

    // Only unmasked requesters take part in the search
    assign cand = req & ~excl;

    // Walk the candidates starting at 'start'; the first one found wins
    always_comb begin : search
        int j;
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        j           = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start) + i) % N;
            if (!pick_any && cand[j]) begin
                pick_any       = 1'b1;
                pick_onehot[j] = 1'b1;
                pick_idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/usb_ep_out_rr_arbiter.sv
// usb_ep_out_rr_arbiter: registered round-robin arbiter for the shared USB
// OUT data path. An endpoint keeps its grant for as long as it holds its
// request high. Ownership rotates from a pointer that moves past each
// winner.
// Optional feature macro: USB_EP_OUT_ARB_TIMEOUT_EN. When it is defined, an
// owner that holds the grant for MAX_HOLD cycles while another endpoint is
// waiting is forced to hand over, and o_timeout pulses for that cycle.
module usb_ep_out_rr_arbiter
    import usb_ep_out_rr_arbiter_pkg::*;
#(
    parameter int N_EP_OUT = 1,
    parameter int MAX_HOLD = 64,
    localparam int IDX_W   = calc_idx_w(N_EP_OUT)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_EP_OUT-1:0] i_outEp_req,
    output logic [N_EP_OUT-1:0] o_outEp_grant,
    output logic [IDX_W-1:0]    o_grantIdx,
    output logic                o_grantValid,
    output logic                o_timeout
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EP_OUT - 1);

    usbArbState_t          state;
    logic [N_EP_OUT-1:0]   grant_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      ptr;

    logic [N_EP_OUT-1:0]   pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [IDX_W-1:0]      next_ptr;
    logic                  owner_req;

`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;
`endif

    // The current owner is always excluded from the search. On a release
    // its request is already low, so the mask only matters on a forced
    // hand-over.
    rr_pick #(
        .N     (N_EP_OUT),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (i_outEp_req),
        .start       (ptr),
        .excl        (grant_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    // Pointer value that sits just past the endpoint being granted
    assign next_ptr  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
    assign owner_req = |(i_outEp_req & grant_q);

    // All arbiter state: grant, owner index, rotation pointer, hold counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr     <= '0;
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= BUSY;
                        grant_q <= pick_onehot;
                        idx_q   <= pick_idx;
                        ptr     <= next_ptr;
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        if (pick_any) begin
                            grant_q <= pick_onehot;
                            idx_q   <= pick_idx;
                            ptr     <= next_ptr;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            idx_q   <= '0;
                        end
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
                        if (hold_cnt >= CNT_LAST) begin
                            if (pick_any) begin
                                grant_q   <= pick_onehot;
                                idx_q     <= pick_idx;
                                ptr       <= next_ptr;
                                hold_cnt  <= '0;
                                timeout_q <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign o_outEp_grant = grant_q;
    assign o_grantIdx    = idx_q;
    assign o_grantValid  = |grant_q;

`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_usb_ep_out_rr_arbiter.sv
// Directed testbench for usb_ep_out_rr_arbiter with N_EP_OUT=4, MAX_HOLD=8.
// Expectations follow USB_EP_OUT_ARB_TIMEOUT_EN where the timeout matters.
module tb_usb_ep_out_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       gvalid;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    usb_ep_out_rr_arbiter #(
        .N_EP_OUT (4),
        .MAX_HOLD (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_outEp_req   (req),
        .o_outEp_grant (grant),
        .o_grantIdx    (gidx),
        .o_grantValid  (gvalid),
        .o_timeout     (tmo)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the full output bundle of the arbiter
    task automatic checkAll(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                            input logic ev, input logic et);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(eg));
        checkOutput({tag, ".idx"}, 32'(gidx), 32'(ei));
        checkOutput({tag, ".valid"}, 32'(gvalid), 32'(ev));
        checkOutput({tag, ".timeout"}, 32'(tmo), 32'(et));
    endtask

    initial begin
        int o;
        // Reset held with every endpoint requesting
        applyStimulus(1'b1, 4'b1111);
        tick();
        tick();
        checkAll("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("reset.ptr", 32'(dut.ptr), 32'd0);

        // First edge after reset grants endpoint 0
        applyStimulus(1'b0, 4'b1111);
        tick();
        checkAll("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Rotation: each owner holds 3 cycles then drops its request for one cycle
        for (int step = 0; step < 5; step++) begin
            o = step % 4;
            checkAll($sformatf("rot%0d", step), 4'(1 << o), 2'(o), 1'b1, 1'b0);
            checkOutput($sformatf("rot%0d.ptr", step), 32'(dut.ptr), 32'((o + 1) % 4));
            tick();
            checkOutput($sformatf("rot%0d.hold1", step), 32'(grant), 32'(1 << o));
            tick();
            checkOutput($sformatf("rot%0d.hold2", step), 32'(grant), 32'(1 << o));
            req[o] = 1'b0;
            tick();
            req[o] = 1'b1;
        end
        // Endpoint 1 owns now; ptr is 2
        checkAll("rot_end", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Everything drops: back to idle and ptr does not move
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkAll("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("idle1.ptr", 32'(dut.ptr), 32'd2);

        // Lone requester 2 held for 20 cycles: never released, no timeout
        applyStimulus(1'b0, 4'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkAll($sformatf("solo%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        checkOutput("solo.ptr", 32'(dut.ptr), 32'd3);
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkAll("idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Timeout scenario: endpoint 1 owns, endpoint 3 waits from the next cycle
        applyStimulus(1'b0, 4'b0010);
        tick();
        checkAll("tmo_g0", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        checkAll("tmo_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1010);
        for (int c = 2; c < 8; c++) begin
            tick();
            checkAll($sformatf("tmo_g%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
        checkAll("tmo_g8", 4'b1000, 2'd3, 1'b1, 1'b1);
        checkOutput("tmo_g8.ptr", 32'(dut.ptr), 32'd0);
`else
        checkAll("tmo_g8", 4'b0010, 2'd1, 1'b1, 1'b0);
        checkOutput("tmo_g8.ptr", 32'(dut.ptr), 32'd2);
`endif
        tick();
`ifdef USB_EP_OUT_ARB_TIMEOUT_EN
        checkAll("tmo_g9", 4'b1000, 2'd3, 1'b1, 1'b0);
`else
        checkAll("tmo_g9", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkAll("idle3", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Short pulse on req[0] while endpoint 2 owns is lost
        applyStimulus(1'b0, 4'b0100);
        tick();
        checkAll("pulse_own", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0101);
        tick();
        applyStimulus(1'b0, 4'b0100);
        tick();
        checkAll("pulse_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        tick();
        checkAll("pulse_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        checkAll("pulse_idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a packet clears everything at the next edge
        applyStimulus(1'b0, 4'b1111);
        tick();
        checkOutput("mid_pre.valid", 32'(gvalid), 32'd1);
        applyStimulus(1'b1, 4'b1111);
        tick();
        checkAll("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("mid_rst.ptr", 32'(dut.ptr), 32'd0);
        applyStimulus(1'b0, 4'b1111);
        tick();
        checkAll("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_ep_out_rr_arbiter.md
# usb_ep_out_rr_arbiter

Registered, round-robin successor to the fixed-priority OUT endpoint arbiter. It sits between the USB device core and N_EP_OUT OUT endpoint buffers and grants the shared OUT data path to exactly one endpoint at a time. A grant is locked for the whole of a packet, and ownership rotates fairly between endpoints. An optional hold timeout stops one endpoint from starving the others.

## Interface
Parameters:
- N_EP_OUT, 1, number of OUT endpoints (1..32).
- MAX_HOLD, 64, maximum consecutive grant cycles before forced release while others wait (≥2; used only with timeout compiled in).

Ports:
- i_clk  input  1  single clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_outEp_req  input  N_EP_OUT  per-endpoint request; held high for the duration of the endpoint's packet.
- o_outEp_grant  output  N_EP_OUT  registered grant, one-hot or zero.
- o_grantIdx  output  IDX_W  index of the current owner; IDX_W = max(1, $clog2(N_EP_OUT)); 0 when idle.
- o_grantValid  output  1  high when any grant is asserted.
- o_timeout  output  1  one-cycle pulse on a forced release.

## Operation
- States: IDLE (no owner), BUSY (owner k).
- IDLE: if any request is high, the winner is the first requester found searching from index `ptr` upward, modulo N_EP_OUT. Go to BUSY(winner) and set `ptr` to (winner+1) mod N_EP_OUT.
- BUSY(k), req[k] still high: hold the grant.
- BUSY(k), req[k] low: release. In the same evaluation, arbitrate among the remaining requests starting from `ptr`. There is no idle cycle between owners. If no request is high, go to IDLE.
- The grant never changes while the owner's request is high, except on a timeout.
- A request from a non-owner has no effect until arbitration.
- Requests that go high and low again before being granted are lost. The arbiter keeps no pending memory.
- `ptr` advances only when a grant is issued, never on a release to IDLE.
- N_EP_OUT=1: the grant register follows req[0] with one cycle of delay. `ptr` is a constant 0.
- Invariant: popcount(o_outEp_grant) ≤ 1 at all times.

## Timing
- Reset values: o_outEp_grant=0, o_grantIdx=0, o_grantValid=0, o_timeout=0, `ptr`=0, hold counter=0, state IDLE.
- Grant latency: a request rising at edge t is granted at edge t+1, provided the arbiter is IDLE and the request wins.
- Release latency: owner request falls at edge t. Its grant falls at edge t+1, and the next owner's grant rises at the same edge t+1.
- Simultaneous requests: a single winner is chosen by the rotating search. With ptr=0 this is the lowest index.
- Reset asserted mid-packet: all outputs clear at the next edge, regardless of the request inputs.

## Configuration
- USB_EP_OUT_ARB_TIMEOUT_EN defined:
  - The hold counter increments each BUSY cycle and clears on every grant change. Width is $clog2(MAX_HOLD+1).
  - When the counter reaches MAX_HOLD-1 while req[k] is high, forced arbitration runs at the next edge. The search covers requesters excluding k, starting from `ptr`.
  - If another endpoint wins: ownership moves to it and o_timeout pulses for one cycle, aligned with the new grant.
  - If no other endpoint is requesting: the grant stays with k, the counter saturates, and o_timeout stays low.
- Macro undefined:
  - No counter is instantiated. Grants are held indefinitely.
  - o_timeout is tied to 0 and MAX_HOLD is ignored.

## Structure
- The shared USB package holds:
  - the IDX_W calculation function;
  - the state enum `usbArbState_t` (IDLE, BUSY).
- Sub-module `rr_pick`: combinational rotating first-one finder.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: one-hot pick, index, any.
  - It is reused by the IN-side arbiter.
- All state (grant, `ptr`, counter, state) lives in a single registered process in this module.

## Test plan
Run with N_EP_OUT=4, MAX_HOLD=8, macro defined unless stated.
- Reset with req=4'b1111 held high → all outputs 0 during reset. At the first edge after reset, grant=4'b0001, idx=0.
- req=4'b1111 held, each owner drops its request for one cycle after 3 cycles:
  - Ownership order is 0, 1, 2, 3, 0 with zero idle cycles between owners.
  - `ptr` equals (owner+1) mod 4.
- Only req[2] is high, held for 20 cycles → grant=4'b0100 for all 20 cycles. No timeout, because no competitor is requesting.
- req[1] held high, req[3] rises at cycle 2 → grant moves to endpoint 3 exactly 8 cycles after endpoint 1 was granted, and o_timeout pulses for that one cycle.
- req[0] pulses for 1 cycle while endpoint 2 owns the grant; the owner then releases with no other requests → idle, req[0] never granted, grant=0.
- Macro undefined, repeat the timeout scenario → endpoint 1 keeps the grant indefinitely and o_timeout stays 0.
